ip_eth_rx: RTL and testbench

Receive-side counterpart of the IP transmit framer, with an 8-bit datapath. Accepts an Ethernet header plus an Ethernet payload stream (ethertype already filtered to 0x0800). Parses and checks the 20-byte IPv4 header, then emits the decoded IP header fields and the IP payload stream. Sits between the Ethernet RX demux and the UDP/ICMP receive blocks.

---
 rtl/ip_eth_rx_if.sv | 70 +++++++
 rtl/ip_eth_rx.sv | 180 ++++++++++++++++++
 tb/tb_ip_eth_rx.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_eth_rx_if.sv
// Stream bundle between the Ethernet RX demux, the IPv4 receive parser and the
// UDP/ICMP receivers: Ethernet header + payload in, IP header + payload out.
interface ip_eth_rx_if;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;

  logic        m_ip_hdr_valid;
  logic        m_ip_hdr_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [3:0]  m_ip_version;
  logic [3:0]  m_ip_ihl;
  logic [5:0]  m_ip_dscp;
  logic [1:0]  m_ip_ecn;
  logic [15:0] m_ip_length;
  logic [15:0] m_ip_identification;
  logic [2:0]  m_ip_flags;
  logic [12:0] m_ip_fragment_offset;
  logic [7:0]  m_ip_ttl;
  logic [7:0]  m_ip_protocol;
  logic [15:0] m_ip_header_checksum;
  logic [31:0] m_ip_source_ip;
  logic [31:0] m_ip_dest_ip;
  logic [7:0]  m_ip_payload_axis_tdata;
  logic        m_ip_payload_axis_tvalid;
  logic        m_ip_payload_axis_tready;
  logic        m_ip_payload_axis_tlast;
  logic        m_ip_payload_axis_tuser;

  // Parser side: sinks the Ethernet frame, sources the IP frame
  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready,
    output m_ip_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_ip_version, m_ip_ihl, m_ip_dscp, m_ip_ecn, m_ip_length,
    output m_ip_identification, m_ip_flags, m_ip_fragment_offset,
    output m_ip_ttl, m_ip_protocol, m_ip_header_checksum,
    output m_ip_source_ip, m_ip_dest_ip,
    output m_ip_payload_axis_tdata, m_ip_payload_axis_tvalid,
    output m_ip_payload_axis_tlast, m_ip_payload_axis_tuser,
    input  m_ip_hdr_ready, m_ip_payload_axis_tready
  );

  // Surrounding blocks: source the Ethernet frame, sink the IP frame
  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready,
    input  m_ip_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_ip_version, m_ip_ihl, m_ip_dscp, m_ip_ecn, m_ip_length,
    input  m_ip_identification, m_ip_flags, m_ip_fragment_offset,
    input  m_ip_ttl, m_ip_protocol, m_ip_header_checksum,
    input  m_ip_source_ip, m_ip_dest_ip,
    input  m_ip_payload_axis_tdata, m_ip_payload_axis_tvalid,
    input  m_ip_payload_axis_tlast, m_ip_payload_axis_tuser,
    output m_ip_hdr_ready, m_ip_payload_axis_tready
  );
endinterface

// File: rtl/ip_eth_rx.sv
// IPv4 receive parser: checks the 20-byte header carried in an Ethernet
// payload and emits the decoded header fields followed by the IP payload.
module ip_eth_rx (
  input  logic       clk,
  input  logic       rst,
  ip_eth_rx_if.slave bus,
  output logic       busy,
  output logic       error_header_early_termination,
  output logic       error_payload_early_termination,
  output logic       error_invalid_header,
  output logic       error_invalid_checksum
);
  localparam int unsigned HDR_BYTES = 20;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {IDLE, READ_HEADER, READ_PAYLOAD, DROP} state_t;

  state_t           state;
  logic [CNT_W-1:0] hdr_cnt;
  logic [15:0]      csum_acc;
  logic [7:0]       csum_hi;
  logic [15:0]      pay_remaining;

  logic        hdr_fire;
  logic        pay_ready;
  logic        pay_fire;
  logic        last_hdr_byte;
  logic [7:0]  din;
  logic [16:0] csum_sum;
  logic [15:0] csum_next;

  assign din                           = bus.s_eth_payload_axis_tdata;
  assign bus.s_eth_hdr_ready           = !rst && (state == IDLE) && !bus.m_ip_hdr_valid;
  assign hdr_fire                      = bus.s_eth_hdr_valid && bus.s_eth_hdr_ready;
  assign bus.s_eth_payload_axis_tready = pay_ready;
  assign pay_fire                      = bus.s_eth_payload_axis_tvalid && pay_ready;
  assign last_hdr_byte                 = hdr_cnt == CNT_W'(HDR_BYTES - 1);
  assign busy                          = state != IDLE;

  // Payload input accepted while the single output stage can take a byte
  always_comb begin
    pay_ready = 1'b0;
    case (state)
      READ_HEADER, DROP: pay_ready = 1'b1;
      READ_PAYLOAD:      pay_ready = bus.m_ip_payload_axis_tready || !bus.m_ip_payload_axis_tvalid;
      default:           pay_ready = 1'b0;
    endcase
  end

  // Ones'-complement add of the big-endian word completed by an odd byte
  assign csum_sum  = {1'b0, csum_acc} + {1'b0, csum_hi, din};
  assign csum_next = csum_sum[15:0] + 16'(csum_sum[16]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                           <= IDLE;
      hdr_cnt                         <= '0;
      csum_acc                        <= '0;
      csum_hi                         <= '0;
      pay_remaining                   <= '0;
      error_header_early_termination  <= 1'b0;
      error_payload_early_termination <= 1'b0;
      error_invalid_header            <= 1'b0;
      error_invalid_checksum          <= 1'b0;
      bus.m_ip_hdr_valid              <= 1'b0;
      bus.m_eth_dest_mac              <= '0;
      bus.m_eth_src_mac               <= '0;
      bus.m_eth_type                  <= '0;
      bus.m_ip_version                <= '0;
      bus.m_ip_ihl                    <= '0;
      bus.m_ip_dscp                   <= '0;
      bus.m_ip_ecn                    <= '0;
      bus.m_ip_length                 <= '0;
      bus.m_ip_identification         <= '0;
      bus.m_ip_flags                  <= '0;
      bus.m_ip_fragment_offset        <= '0;
      bus.m_ip_ttl                    <= '0;
      bus.m_ip_protocol               <= '0;
      bus.m_ip_header_checksum        <= '0;
      bus.m_ip_source_ip              <= '0;
      bus.m_ip_dest_ip                <= '0;
      bus.m_ip_payload_axis_tdata     <= '0;
      bus.m_ip_payload_axis_tvalid    <= 1'b0;
      bus.m_ip_payload_axis_tlast     <= 1'b0;
      bus.m_ip_payload_axis_tuser     <= 1'b0;
    end else begin
      error_header_early_termination  <= 1'b0;
      error_payload_early_termination <= 1'b0;
      error_invalid_header            <= 1'b0;
      error_invalid_checksum          <= 1'b0;
      if (bus.m_ip_hdr_valid && bus.m_ip_hdr_ready) bus.m_ip_hdr_valid <= 1'b0;
      if (bus.m_ip_payload_axis_tvalid && bus.m_ip_payload_axis_tready)
        bus.m_ip_payload_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (hdr_fire) begin
            bus.m_eth_dest_mac <= bus.s_eth_dest_mac;
            bus.m_eth_src_mac  <= bus.s_eth_src_mac;
            bus.m_eth_type     <= bus.s_eth_type;
            hdr_cnt            <= '0;
            csum_acc           <= '0;
            state              <= READ_HEADER;
          end
        end
        READ_HEADER: begin
          if (pay_fire) begin
            hdr_cnt <= hdr_cnt + CNT_W'(1);
            if (hdr_cnt[0]) csum_acc <= csum_next;
            else            csum_hi  <= din;
            case (hdr_cnt)
              5'd0:  {bus.m_ip_version, bus.m_ip_ihl} <= din;
              5'd1:  {bus.m_ip_dscp, bus.m_ip_ecn} <= din;
              5'd2:  bus.m_ip_length[15:8] <= din;
              5'd3:  bus.m_ip_length[7:0] <= din;
              5'd4:  bus.m_ip_identification[15:8] <= din;
              5'd5:  bus.m_ip_identification[7:0] <= din;
              5'd6:  {bus.m_ip_flags, bus.m_ip_fragment_offset[12:8]} <= din;
              5'd7:  bus.m_ip_fragment_offset[7:0] <= din;
              5'd8:  bus.m_ip_ttl <= din;
              5'd9:  bus.m_ip_protocol <= din;
              5'd10: bus.m_ip_header_checksum[15:8] <= din;
              5'd11: bus.m_ip_header_checksum[7:0] <= din;
              5'd12: bus.m_ip_source_ip[31:24] <= din;
              5'd13: bus.m_ip_source_ip[23:16] <= din;
              5'd14: bus.m_ip_source_ip[15:8] <= din;
              5'd15: bus.m_ip_source_ip[7:0] <= din;
              5'd16: bus.m_ip_dest_ip[31:24] <= din;
              5'd17: bus.m_ip_dest_ip[23:16] <= din;
              5'd18: bus.m_ip_dest_ip[15:8] <= din;
              5'd19: bus.m_ip_dest_ip[7:0] <= din;
              default: ;
            endcase
            if (bus.s_eth_payload_axis_tlast) begin
              error_header_early_termination <= 1'b1;
              state                          <= IDLE;
            end else if (last_hdr_byte) begin
              // version, ihl and length were all latched by earlier bytes
              if (bus.m_ip_version != 4'd4 || bus.m_ip_ihl != 4'd5 || bus.m_ip_length < 16'd21) begin
                error_invalid_header <= 1'b1;
                state                <= DROP;
              end else if (csum_next != 16'hFFFF) begin
                error_invalid_checksum <= 1'b1;
                state                  <= DROP;
              end else begin
                bus.m_ip_hdr_valid <= 1'b1;
                pay_remaining      <= bus.m_ip_length - 16'(HDR_BYTES);
                state              <= READ_PAYLOAD;
              end
            end
          end
        end
        READ_PAYLOAD: begin
          if (pay_fire) begin
            bus.m_ip_payload_axis_tdata  <= din;
            bus.m_ip_payload_axis_tvalid <= 1'b1;
            if (pay_remaining == 16'd1) begin
              bus.m_ip_payload_axis_tlast <= 1'b1;
              bus.m_ip_payload_axis_tuser <= bus.s_eth_payload_axis_tuser;
              state <= bus.s_eth_payload_axis_tlast ? IDLE : DROP;
            end else if (bus.s_eth_payload_axis_tlast) begin
              bus.m_ip_payload_axis_tlast     <= 1'b1;
              bus.m_ip_payload_axis_tuser     <= 1'b1;
              error_payload_early_termination <= 1'b1;
              state                           <= IDLE;
            end else begin
              bus.m_ip_payload_axis_tlast <= 1'b0;
              bus.m_ip_payload_axis_tuser <= bus.s_eth_payload_axis_tuser;
              pay_remaining               <= pay_remaining - 16'd1;
            end
          end
        end
        DROP: begin
          if (pay_fire && bus.s_eth_payload_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_eth_rx.sv
// Bench for ip_eth_rx: directed and random frames scored against a
// byte-level model of IPv4 header parsing and payload trimming.
module tb_ip_eth_rx;
  logic clk;
  logic rst;
  logic busy;
  logic err_hdr_early, err_pay_early, err_inv_hdr, err_inv_csum;

  ip_eth_rx_if bus ();

  ip_eth_rx dut (
    .clk                             (clk),
    .rst                             (rst),
    .bus                             (bus),
    .busy                            (busy),
    .error_header_early_termination  (err_hdr_early),
    .error_payload_early_termination (err_pay_early),
    .error_invalid_header            (err_inv_hdr),
    .error_invalid_checksum          (err_inv_csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit bp_en   = 1'b0;

  logic [7:0]   tx_data[$];
  logic         tx_user[$];
  logic [47:0]  tx_dmac, tx_smac;
  logic [15:0]  tx_type;

  logic [7:0]   rx_data[$];
  logic         rx_last[$];
  logic         rx_user[$];
  int           hdr_seen, cnt_hdr_early, cnt_pay_early, cnt_inv_hdr, cnt_inv_csum;
  logic [159:0] cap_ip;
  logic [111:0] cap_eth;

  logic [7:0]   ex_data[$];
  logic         ex_last[$];
  logic         ex_user[$];
  int           ex_hdr, ex_hdr_early, ex_pay_early, ex_inv_hdr, ex_inv_csum;
  logic [159:0] ex_ip;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sink-side randomized backpressure
  always @(posedge clk) begin
    #1;
    bus.m_ip_payload_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    bus.m_ip_hdr_ready           = bp_en ? ($urandom_range(0, 3) == 0) : 1'b1;
  end

  // Output monitor: handshakes seen at negedge complete on the next posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_ip_payload_axis_tvalid && bus.m_ip_payload_axis_tready) begin
        rx_data.push_back(bus.m_ip_payload_axis_tdata);
        rx_last.push_back(bus.m_ip_payload_axis_tlast);
        rx_user.push_back(bus.m_ip_payload_axis_tuser);
      end
      if (bus.m_ip_hdr_valid && bus.m_ip_hdr_ready) begin
        hdr_seen++;
        cap_ip = {bus.m_ip_version, bus.m_ip_ihl, bus.m_ip_dscp, bus.m_ip_ecn, bus.m_ip_length,
                  bus.m_ip_identification, bus.m_ip_flags, bus.m_ip_fragment_offset,
                  bus.m_ip_ttl, bus.m_ip_protocol, bus.m_ip_header_checksum,
                  bus.m_ip_source_ip, bus.m_ip_dest_ip};
        cap_eth = {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type};
      end
      cnt_hdr_early += int'(err_hdr_early);
      cnt_pay_early += int'(err_pay_early);
      cnt_inv_hdr   += int'(err_inv_hdr);
      cnt_inv_csum  += int'(err_inv_csum);
    end
  end

  task automatic build_frame(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] len,
                             input logic [7:0] ttl, input logic [7:0] proto,
                             input logic [31:0] src, input logic [31:0] dst,
                             input bit bad_csum, input int total);
    logic [7:0]  h[20];
    logic [31:0] s;
    logic [15:0] cs;
    h[0] = {ver, ihl};        h[1] = 8'($urandom);
    h[2] = len[15:8];         h[3] = len[7:0];
    h[4] = 8'($urandom);      h[5] = 8'($urandom);
    h[6] = 8'($urandom);      h[7] = 8'($urandom);
    h[8] = ttl;               h[9] = proto;
    h[10] = 8'h00;            h[11] = 8'h00;
    h[12] = src[31:24]; h[13] = src[23:16]; h[14] = src[15:8]; h[15] = src[7:0];
    h[16] = dst[31:24]; h[17] = dst[23:16]; h[18] = dst[15:8]; h[19] = dst[7:0];
    s = 32'd0;
    for (int i = 0; i < 10; i++) s += {16'd0, h[2*i], h[2*i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    if (bad_csum) cs = cs ^ 16'h0001;
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    tx_data.delete();
    tx_user.delete();
    for (int i = 0; i < total; i++) begin
      tx_data.push_back(i < 20 ? h[i] : 8'($urandom));
      tx_user.push_back(i >= 20 && $urandom_range(0, 7) == 0);
    end
    tx_dmac = 48'({$urandom, $urandom});
    tx_smac = 48'({$urandom, $urandom});
    tx_type = 16'h0800;
  endtask

  // Reference: what the receive path must produce for the frame in tx_*
  task automatic model_frame();
    logic [31:0] s;
    logic [15:0] len;
    logic [7:0]  b0;
    int sz, n, rem, cnt;
    ex_data.delete(); ex_last.delete(); ex_user.delete();
    ex_hdr = 0; ex_hdr_early = 0; ex_pay_early = 0; ex_inv_hdr = 0; ex_inv_csum = 0;
    ex_ip = '0;
    sz = tx_data.size();
    if (sz <= 20) begin
      ex_hdr_early = 1;
      return;
    end
    b0  = tx_data[0];
    len = {tx_data[2], tx_data[3]};
    if (b0[7:4] != 4'd4 || b0[3:0] != 4'd5 || len < 16'd21) begin
      ex_inv_hdr = 1;
      return;
    end
    s = 32'd0;
    for (int i = 0; i < 10; i++) s += {16'd0, tx_data[2*i], tx_data[2*i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    if (s[15:0] != 16'hFFFF) begin
      ex_inv_csum = 1;
      return;
    end
    ex_hdr = 1;
    for (int i = 0; i < 20; i++) ex_ip = {ex_ip[151:0], tx_data[i]};
    rem = int'(len) - 20;
    n   = sz - 20;
    cnt = (n < rem) ? n : rem;
    for (int i = 0; i < cnt; i++) begin
      ex_data.push_back(tx_data[20+i]);
      ex_last.push_back(i == cnt - 1);
      ex_user.push_back(tx_user[20+i] || (n < rem && i == cnt - 1));
    end
    ex_pay_early = (n < rem) ? 1 : 0;
  endtask

  // Sends header then bytes; stop_at >= 0 abandons the frame after that many bytes
  task automatic drive_frame(input int stop_at);
    int guard;
    bit fired;
    int sz;
    sz = tx_data.size();
    @(posedge clk); #1;
    bus.s_eth_dest_mac  = tx_dmac;
    bus.s_eth_src_mac   = tx_smac;
    bus.s_eth_type      = tx_type;
    bus.s_eth_hdr_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk); fired = bus.s_eth_hdr_ready; guard++;
      @(posedge clk); #1;
    end while (!fired && guard < 500);
    bus.s_eth_hdr_valid = 1'b0;
    if (!fired) begin
      check("hdr_accept_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < sz && i != stop_at; i++) begin
      if (bp_en && $urandom_range(0, 3) == 0) begin
        bus.s_eth_payload_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_eth_payload_axis_tvalid = 1'b1;
      bus.s_eth_payload_axis_tdata  = tx_data[i];
      bus.s_eth_payload_axis_tlast  = (i == sz - 1);
      bus.s_eth_payload_axis_tuser  = tx_user[i];
      guard = 0;
      do begin
        @(negedge clk); fired = bus.s_eth_payload_axis_tready; guard++;
        @(posedge clk); #1;
      end while (!fired && guard < 500);
      if (!fired) begin
        check("byte_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    bus.s_eth_payload_axis_tvalid = 1'b0;
    bus.s_eth_payload_axis_tlast  = 1'b0;
    bus.s_eth_payload_axis_tuser  = 1'b0;
  endtask

  task automatic clear_capture();
    rx_data.delete(); rx_last.delete(); rx_user.delete();
    hdr_seen = 0; cnt_hdr_early = 0; cnt_pay_early = 0; cnt_inv_hdr = 0; cnt_inv_csum = 0;
  endtask

  task automatic run_frame(input string name);
    int guard;
    int nb;
    clear_capture();
    model_frame();
    drive_frame(-1);
    guard = 0;
    while ((busy || bus.m_ip_payload_axis_tvalid || bus.m_ip_hdr_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check({name, "/drain_timeout"}, 64'(guard >= 1000), 64'd0);
    repeat (2) @(negedge clk);
    check({name, "/busy"}, 64'(busy), 64'd0);
    check({name, "/hdr_count"}, 64'(hdr_seen), 64'(ex_hdr));
    if (ex_hdr != 0 && hdr_seen != 0) begin
      for (int w = 0; w < 5; w++)
        check($sformatf("%s/ip_hdr_w%0d", name, w), 64'(cap_ip[159-32*w -: 32]),
              64'(ex_ip[159-32*w -: 32]));
      check({name, "/dest_mac"}, 64'(cap_eth[111:64]), 64'(tx_dmac));
      check({name, "/src_mac"}, 64'(cap_eth[63:16]), 64'(tx_smac));
      check({name, "/eth_type"}, 64'(cap_eth[15:0]), 64'(tx_type));
    end
    check({name, "/err_hdr_early"}, 64'(cnt_hdr_early), 64'(ex_hdr_early));
    check({name, "/err_pay_early"}, 64'(cnt_pay_early), 64'(ex_pay_early));
    check({name, "/err_inv_hdr"}, 64'(cnt_inv_hdr), 64'(ex_inv_hdr));
    check({name, "/err_inv_csum"}, 64'(cnt_inv_csum), 64'(ex_inv_csum));
    check({name, "/pay_count"}, 64'(rx_data.size()), 64'(ex_data.size()));
    nb = (rx_data.size() < ex_data.size()) ? rx_data.size() : ex_data.size();
    for (int i = 0; i < nb; i++) begin
      check($sformatf("%s/data%0d", name, i), 64'(rx_data[i]), 64'(ex_data[i]));
      check($sformatf("%s/last%0d", name, i), 64'(rx_last[i]), 64'(ex_last[i]));
      check($sformatf("%s/user%0d", name, i), 64'(rx_user[i]), 64'(ex_user[i]));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/s_hdr_ready"}, 64'(bus.s_eth_hdr_ready), 64'd0);
    check({tag, "/s_tready"}, 64'(bus.s_eth_payload_axis_tready), 64'd0);
    check({tag, "/m_hdr_valid"}, 64'(bus.m_ip_hdr_valid), 64'd0);
    check({tag, "/m_tvalid"}, 64'(bus.m_ip_payload_axis_tvalid), 64'd0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/errors"}, 64'({err_hdr_early, err_pay_early, err_inv_hdr, err_inv_csum}), 64'd0);
    check({tag, "/ttl"}, 64'(bus.m_ip_ttl), 64'd0);
    check({tag, "/length"}, 64'(bus.m_ip_length), 64'd0);
    check({tag, "/src_ip"}, 64'(bus.m_ip_source_ip), 64'd0);
    check({tag, "/src_mac"}, 64'(bus.m_eth_src_mac), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ver, ihl;
    logic [15:0] len;
    int          total;
    bit          bad;
    rst = 1'b1;
    bus.s_eth_hdr_valid           = 1'b0;
    bus.s_eth_dest_mac            = '0;
    bus.s_eth_src_mac             = '0;
    bus.s_eth_type                = '0;
    bus.s_eth_payload_axis_tdata  = '0;
    bus.s_eth_payload_axis_tvalid = 1'b0;
    bus.s_eth_payload_axis_tlast  = 1'b0;
    bus.s_eth_payload_axis_tuser  = 1'b0;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    build_frame(4'd4, 4'd5, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 32);
    run_frame("good");
    check("good/ttl", 64'(bus.m_ip_ttl), 64'd64);
    check("good/protocol", 64'(bus.m_ip_protocol), 64'h11);
    check("good/length", 64'(bus.m_ip_length), 64'h20);
    check("good/src_ip", 64'(bus.m_ip_source_ip), 64'h0A000001);
    check("good/dst_ip", 64'(bus.m_ip_dest_ip), 64'h0A000002);

    build_frame(4'd4, 4'd5, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b1, 32);
    run_frame("bad_csum");
    build_frame(4'd4, 4'd5, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 52);
    run_frame("trailing");
    build_frame(4'd4, 4'd5, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 25);
    run_frame("pay_early");
    build_frame(4'd4, 4'd5, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 11);
    run_frame("hdr_early");
    build_frame(4'd4, 4'd5, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 20);
    run_frame("hdr_early_b19");
    build_frame(4'd4, 4'd6, 16'h0020, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 32);
    run_frame("ihl6");
    build_frame(4'd4, 4'd5, 16'd20, 8'd64, 8'h11, 32'h0A000001, 32'h0A000002, 1'b0, 32);
    run_frame("len20");
    build_frame(4'd4, 4'd5, 16'd21, 8'd9, 8'h01, 32'hC0A80101, 32'hC0A80102, 1'b0, 21);
    run_frame("len21");

    bp_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ver   = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'd4;
      ihl   = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'd5;
      len   = ($urandom_range(0, 11) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(21, 60));
      bad   = ($urandom_range(0, 7) == 0);
      total = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : 20 + int'($urandom_range(1, 50));
      build_frame(ver, ihl, len, 8'($urandom), 8'($urandom), $urandom, $urandom, bad, total);
      run_frame($sformatf("rand%0d", k));
    end

    build_frame(4'd4, 4'd5, 16'd64, 8'd32, 8'h06, 32'hC0A80001, 32'hC0A80002, 1'b0, 84);
    clear_capture();
    drive_frame(30);
    check("mid_rst/busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_cleared("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    build_frame(4'd4, 4'd5, 16'd48, 8'd128, 8'h11, 32'h0A000005, 32'h0A000006, 1'b0, 48);
    run_frame("after_rst");
    build_frame(4'd4, 4'd5, 16'd30, 8'd1, 8'h01, 32'h0A000007, 32'h0A000008, 1'b0, 30);
    run_frame("back_to_back");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
